// File: rtl/seq_fetch_control.sv
// Multicycle fetch/control sequencer: instruction RAM, program counter and
// a FETCH..WB state machine driving the datapath control strobes.
module seq_fetch_control #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  wea,
    input  logic                  run,
    input  logic                  alu_zero,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [2:0]            state,
    output logic                  alusrc,
    output logic                  memtoreg,
    output logic                  regdest,
    output logic                  regwrite,
    output logic                  memread,
    output logic                  memwrite,
    output logic                  branch,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  ill_q, ill_d;
    logic [CNT_WIDTH-1:0]  ret_q, ret_d;

    logic [3:0]            op_dec;
    logic [3:0]            op_ex;
    logic                  dec_legal;
    logic                  load_ok;
    logic [ADDR_WIDTH-1:0] br_off;

    assign op_dec    = rdata_q[DATA_WIDTH-1 -: 4];
    assign op_ex     = instr_q[DATA_WIDTH-1 -: 4];
    assign dec_legal = (op_dec <= OP_JMP);
    assign load_ok   = (state_q == S_IDLE) || (state_q == S_HALT);
    assign br_off    = {{(ADDR_WIDTH-8){instr_q[7]}}, instr_q[7:0]};

    // RAM is never reset; the read port is registered at the end of FETCH
    always_ff @(posedge clock) begin
        if (wea && load_ok && !reset)
            mem_q[addra] <= dina;
        if (state_q == S_FETCH)
            rdata_q <= mem_q[pc_q];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            ill_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ill_q   <= ill_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ill_d   = ill_q;
        ret_d   = ret_q;
        case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                instr_d = rdata_q;
                if (op_dec == OP_HALT) begin
                    state_d = S_HALT;
                end else if (!dec_legal) begin
                    state_d = S_FETCH;
                    ill_d   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_ex)
                    OP_BEQ: begin
                        if (alu_zero)
                            pc_d = pc_q + br_off;
                        state_d = S_FETCH;
                        ret_d   = ret_q + CNT_WIDTH'(1);
                    end
                    OP_JMP: begin
                        pc_d    = instr_q[ADDR_WIDTH-1:0];
                        state_d = S_FETCH;
                        ret_d   = ret_q + CNT_WIDTH'(1);
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (op_ex == OP_LW) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                    ret_d   = ret_q + CNT_WIDTH'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                ret_d   = ret_q + CNT_WIDTH'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regdest  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_EXEC: begin
                alusrc = (op_ex == OP_ADDI) || (op_ex == OP_LW) || (op_ex == OP_SW);
                branch = (op_ex == OP_BEQ);
            end
            S_MEM: begin
                memread  = (op_ex == OP_LW);
                memwrite = (op_ex == OP_SW);
            end
            S_WB: begin
                regwrite = (op_ex == OP_R) || (op_ex == OP_ADDI) || (op_ex == OP_LW);
                regdest  = (op_ex == OP_R);
                memtoreg = (op_ex == OP_LW);
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign pc      = pc_q;
    assign instr   = instr_q;
    assign illegal = ill_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_seq_fetch_control.sv
// Bench for seq_fetch_control: instruction-level schedule model checked
// every cycle, plus directed programs with literal expectations.
module tb_seq_fetch_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic        wea;
    logic        run;
    logic        alu_zero;
    logic [15:0] instr;
    logic [9:0]  pc;
    logic [2:0]  state;
    logic        alusrc, memtoreg, regdest, regwrite;
    logic        memread, memwrite, branch;
    logic        illegal;
    logic [15:0] retired;

    always #5 clock = ~clock;

    seq_fetch_control dut (
        .clock(clock), .reset(reset), .addra(addra), .dina(dina),
        .wea(wea), .run(run), .alu_zero(alu_zero), .instr(instr),
        .pc(pc), .state(state), .alusrc(alusrc), .memtoreg(memtoreg),
        .regdest(regdest), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .branch(branch), .illegal(illegal),
        .retired(retired)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endfunction

    // strobe order: alusrc memtoreg regdest regwrite memread memwrite branch
    typedef struct packed {
        logic [2:0]  st;
        logic [9:0]  pc;
        logic [15:0] ins;
        logic [6:0]  strb;
        logic        ill;
        logic [15:0] ret;
    } rec_t;

    logic [15:0] mmem [0:1023];
    rec_t        cur;
    rec_t        sched [$];
    logic [15:0] m_ins;
    logic        m_ill;
    logic [15:0] m_ret;
    logic [9:0]  npc;
    logic        pend_halt;
    logic        chk_en = 1'b0;

    function automatic rec_t mk(logic [2:0] s, logic [9:0] p, logic [6:0] sb);
        rec_t r;
        r.st = s; r.pc = p; r.ins = m_ins; r.strb = sb;
        r.ill = m_ill; r.ret = m_ret;
        return r;
    endfunction

    // Expand one whole instruction into its per-cycle expected outputs.
    task automatic gen();
        logic [15:0] w;
        logic [9:0]  a1;
        logic [3:0]  op;
        logic        inc;
        w  = mmem[npc];
        op = w[15:12];
        a1 = npc + 10'd1;
        inc = 1'b1;
        sched.push_back(mk(3'd1, npc, 7'b0));
        sched.push_back(mk(3'd2, a1, 7'b0));
        m_ins = w;
        npc = a1;
        case (op)
            4'd0: begin
                sched.push_back(mk(3'd3, a1, 7'b0000000));
                sched.push_back(mk(3'd5, a1, 7'b0011000));
            end
            4'd1: begin
                sched.push_back(mk(3'd3, a1, 7'b1000000));
                sched.push_back(mk(3'd5, a1, 7'b0001000));
            end
            4'd2: begin
                sched.push_back(mk(3'd3, a1, 7'b1000000));
                sched.push_back(mk(3'd4, a1, 7'b0000100));
                sched.push_back(mk(3'd5, a1, 7'b0101000));
            end
            4'd3: begin
                sched.push_back(mk(3'd3, a1, 7'b1000000));
                sched.push_back(mk(3'd4, a1, 7'b0000010));
            end
            4'd4: begin
                sched.push_back(mk(3'd3, a1, 7'b0000001));
                if (alu_zero)
                    npc = a1 + {{2{w[7]}}, w[7:0]};
            end
            4'd5: begin
                sched.push_back(mk(3'd3, a1, 7'b0));
                npc = w[9:0];
            end
            4'd15: begin
                pend_halt = 1'b1;
                inc = 1'b0;
            end
            default: begin
                m_ill = 1'b1;
                inc = 1'b0;
            end
        endcase
        if (inc)
            m_ret = m_ret + 16'd1;
    endtask

    always @(posedge clock) begin
        if (reset) begin
            cur = '0;
            sched.delete();
            m_ins = '0; m_ill = 1'b0; m_ret = '0;
            npc = '0; pend_halt = 1'b0;
        end else if (cur.st == 3'd0 || cur.st == 3'd6) begin
            if (wea)
                mmem[addra] = dina;
            if (run) begin
                if (cur.st == 3'd6)
                    npc = '0;
                gen();
                cur = sched.pop_front();
            end
        end else if (sched.size() == 0) begin
            if (pend_halt) begin
                cur = mk(3'd6, npc, 7'b0);
                pend_halt = 1'b0;
            end else begin
                gen();
                cur = sched.pop_front();
            end
        end else begin
            cur = sched.pop_front();
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(cur.st));
            chk("pc", 32'(pc), 32'(cur.pc));
            chk("instr", 32'(instr), 32'(cur.ins));
            chk("strobes", 32'({alusrc, memtoreg, regdest, regwrite,
                                memread, memwrite, branch}), 32'(cur.strb));
            chk("illegal", 32'(illegal), 32'(cur.ill));
            chk("retired", 32'(retired), 32'(cur.ret));
        end
    end

    logic [63:0] seq;
    int          cnt_mr, cnt_mw, n;

    task automatic load(input logic [9:0] a, input logic [15:0] d);
        wea = 1'b1; addra = a; dina = d;
        @(negedge clock);
        wea = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 1;
        seq = 64'(state);
        while (state != 3'd6 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            seq = (seq << 3) | 64'(state);
            if (memread) cnt_mr++;
            if (memwrite) cnt_mw++;
        end
        chk("halt_reached", 32'(state), 32'd6);
    endtask

    task automatic wait_state(input logic [2:0] s);
        int k;
        k = 0;
        while (state != s && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("state_reached", 32'(state), 32'(s));
    endtask

    initial begin
        reset = 1'b1; wea = 1'b0; run = 1'b0; alu_zero = 1'b0;
        addra = '0; dina = '0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        reset = 1'b0;

        // R-type then halt
        load(10'd0, 16'h0000);
        load(10'd1, 16'hF000);
        pulse_run();
        wait_halt(n);
        chk("t1_seq", seq[31:0], 32'o1235126);
        chk("t1_retired", 32'(retired), 32'd1);
        chk("t1_pc", 32'(pc), 32'd2);

        // lw, sw, halt
        do_reset();
        load(10'd0, 16'h2000);
        load(10'd1, 16'h3000);
        load(10'd2, 16'hF000);
        cnt_mr = 0; cnt_mw = 0;
        pulse_run();
        wait_halt(n);
        chk("t2_cycles", 32'(n), 32'd12);
        chk("t2_memread_cycles", 32'(cnt_mr), 32'd1);
        chk("t2_memwrite_cycles", 32'(cnt_mw), 32'd1);
        chk("t2_retired", 32'(retired), 32'd2);

        // beq taken and not taken
        do_reset();
        load(10'd0, 16'h5004);
        load(10'd3, 16'hF000);
        load(10'd4, 16'h40FE);
        load(10'd5, 16'hF000);
        alu_zero = 1'b1;
        pulse_run();
        wait_halt(n);
        chk("t3_taken_cycles", 32'(n), 32'd9);
        chk("t3_taken_pc", 32'(pc), 32'd4);
        alu_zero = 1'b0;
        pulse_run();
        wait_halt(n);
        chk("t3_nt_pc", 32'(pc), 32'd6);
        chk("t3_retired", 32'(retired), 32'd4);

        // jump to top of RAM, then wrap
        do_reset();
        load(10'd0, 16'h53FF);
        load(10'h3FF, 16'hF000);
        pulse_run();
        wait_halt(n);
        chk("t4_cycles", 32'(n), 32'd6);
        chk("t4_halt_pc", 32'(pc), 32'd0);
        chk("t4_instr", 32'(instr), 32'hF000);
        load(10'h3FF, 16'h0000);
        pulse_run();
        repeat (4) @(negedge clock);
        chk("t4_wrap_state", 32'(state), 32'd2);
        chk("t4_wrap_pc", 32'(pc), 32'd0);

        // write attempt during EXEC, illegal opcode
        do_reset();
        load(10'd0, 16'h0000);
        load(10'd1, 16'h7000);
        load(10'd2, 16'hF000);
        pulse_run();
        repeat (2) @(negedge clock);
        wea = 1'b1; addra = 10'd2; dina = 16'h1000;
        @(negedge clock);
        wea = 1'b0;
        wait_halt(n);
        chk("t5_illegal", 32'(illegal), 32'd1);
        chk("t5_retired", 32'(retired), 32'd1);
        chk("t5_instr", 32'(instr), 32'hF000);
        pulse_run();
        wait_halt(n);
        chk("t5_rerun_instr", 32'(instr), 32'hF000);
        chk("t5_rerun_retired", 32'(retired), 32'd2);

        // reset during MEM of lw
        do_reset();
        load(10'd0, 16'h2000);
        load(10'd1, 16'hF000);
        pulse_run();
        wait_state(3'd4);
        do_reset();
        chk("t6_state", 32'(state), 32'd0);
        chk("t6_pc", 32'(pc), 32'd0);
        chk("t6_memread", 32'(memread), 32'd0);
        pulse_run();
        wait_halt(n);
        chk("t6_retired", 32'(retired), 32'd1);
        chk("t6_pc_end", 32'(pc), 32'd2);

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
